cruzamento_ctrl: RTL
====================

CRUZAMENTO_CTRL -- requirements
Module: cruzamento_ctrl

Interface
REQ-001 Parameter GREEN_MIN, default 4: minimum green dwell in cycles, both roads.
REQ-002 Parameter GREEN_MAX, default 12: maximum road-B green dwell in cycles.
REQ-003 Parameter YELLOW_T, default 2: yellow dwell in cycles.
REQ-004 Parameter RED_T, default 1: all-red clearance dwell in cycles.
REQ-005 Parameter WALK_T, default 6: pedestrian walk dwell in cycles (PED_EN only).
REQ-006 Parameter CNT_W, default 4: phase counter width; every dwell parameter SHALL be ≤ 2^CNT_W.
REQ-007 clk  in  1  single clock; all state changes on its rising edge.
REQ-008 res  in  1  reset; synchronous, active-low.
REQ-009 car_a  in  1  vehicle present on road A (main road).
REQ-010 car_b  in  1  vehicle present on road B (side road).
REQ-011 grn_a, ylw_a, red_a  out  1 each  road-A lamps.
REQ-012 grn_b, ylw_b, red_b  out  1 each  road-B lamps.
REQ-013 phase  out  3  current state encoding, for debug and bench use.
REQ-014 ped_req  in  1  pedestrian button (PED_EN only).
REQ-015 walk  out  1  pedestrian walk lamp (PED_EN only).

Function
REQ-016 States: A_GRN=0, A_YLW=1, RED_AB=2, B_GRN=3, B_YLW=4, RED_BA=5, WALK=6 (PED_EN only).
REQ-017 Moore outputs, decoded from the state register only; no combinational input-to-output path.
REQ-018 The phase counter SHALL clear to 0 on every state change and increment once per cycle; dwell N means the state holds exactly N cycles.
REQ-019 A_GRN -> A_YLW when counter ≥ GREEN_MIN-1 and (car_b or ped_pend); otherwise stay, with the counter saturating at GREEN_MIN-1.
REQ-020 A_YLW -> RED_AB after YELLOW_T cycles; B_YLW -> RED_BA after YELLOW_T cycles.
REQ-021 RED_AB -> B_GRN after RED_T cycles; RED_BA -> A_GRN after RED_T cycles (unless REQ-031 applies).
REQ-022 B_GRN -> B_YLW when counter ≥ GREEN_MIN-1 and (!car_b or car_a or ped_pend), or unconditionally when counter = GREEN_MAX-1.
REQ-023 Each road SHALL have exactly one lamp lit per cycle: A_GRN lights grn_a, A_YLW lights ylw_a, and all other states light red_a; road B is symmetric.
REQ-024 grn/ylw SHALL never be active on both roads in the same cycle; walk SHALL be 1 only in WALK, when both reds are lit.
REQ-025 car_a/car_b changes SHALL affect phase no earlier than the first rising edge that samples them.

Reset
REQ-026 res=0 at a rising edge SHALL force state A_GRN, counter 0, and ped_pend 0, whatever the current state.
REQ-027 Reset outputs: grn_a=1, red_b=1, phase=0, walk=0, and all other lamps 0.
REQ-028 Reset SHALL take priority over every simultaneous input event.

Configuration
REQ-029 The macro CRUZAMENTO_PED_EN SHALL compile in ped_req, walk, the ped_pend flag and the WALK state; without it these are absent and ped_pend reads as constant 0.
REQ-030 With the macro defined, a ped_req=1 sample SHALL set ped_pend in any state except WALK; ped_pend SHALL clear on WALK entry, and ped_req during WALK SHALL be ignored.
REQ-031 With the macro defined, RED_AB or RED_BA with ped_pend=1 SHALL go to WALK instead of the next green; WALK holds WALK_T cycles, then enters the green that RED_xx would have entered, held in a next-road register.

Structure
REQ-032 Package cruzamento_pkg SHALL hold the state enum, the phase encodings and the parameter defaults.
REQ-033 Sub-module phase_timer SHALL hold the CNT_W counter, with clear, saturate-at-limit and expired (count = limit-1) outputs.

Verification
REQ-034 res=0 for 2 cycles, then 1, with no cars -> grn_a=1, red_b=1, phase=0, held indefinitely.
REQ-035 car_b=1 held from reset release -> A_GRN 4 cycles, A_YLW 2, RED_AB 1, then B_GRN (phase=3).
REQ-036 car_b=1 and car_a=0 held in B_GRN -> exactly 12 cycles of B_GRN, then B_YLW, RED_BA and A_GRN.
REQ-037 car_b dropped on B_GRN entry -> B_GRN held 4 cycles, then B_YLW.
REQ-038 res=0 on the 2nd cycle of A_YLW -> next cycle A_GRN, counter 0, grn_a=1.
REQ-039 PED_EN, no cars, 1-cycle ped_req pulse in A_GRN -> A_YLW after the minimum green, RED_AB, WALK for 6 cycles with walk=1 and both reds lit, then B_GRN.

Source files
------------

// File: rtl/cruzamento_pkg.sv
`default_nettype none
// ============================================================================
// cruzamento_pkg : state/phase encodings and parameter defaults for the
//                  two-road crossing controller (CRUZAMENTO_PED_EN adds WALK)
// Revision       : 1.0
// ============================================================================
package cruzamento_pkg;

    localparam int DEF_GREEN_MIN = 4;
    localparam int DEF_GREEN_MAX = 12;
    localparam int DEF_YELLOW_T  = 2;
    localparam int DEF_RED_T     = 1;
    localparam int DEF_WALK_T    = 6;
    localparam int DEF_CNT_W     = 4;

    // The enum values are the externally visible phase encodings.
    typedef enum logic [2:0] {
        A_GRN  = 3'd0,
        A_YLW  = 3'd1,
        RED_AB = 3'd2,
        B_GRN  = 3'd3,
        B_YLW  = 3'd4,
`ifdef CRUZAMENTO_PED_EN
        RED_BA = 3'd5,
        WALK   = 3'd6
`else
        RED_BA = 3'd5
`endif
    } state_t;

endpackage : cruzamento_pkg
`default_nettype wire

// File: rtl/phase_timer.sv
`default_nettype none
// ============================================================================
// phase_timer : dwell counter; clears on request, counts up and saturates at
//               lim_i-1, flagging exp_o while it sits there
// Revision    : 1.0
// ============================================================================
module phase_timer
    import cruzamento_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             res,
    input  logic             clr_i,
    input  logic [CNT_W:0]   lim_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             exp_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W:0]   last;

    // One extra bit so a dwell of exactly 2^CNT_W is still representable.
    assign last  = lim_i - (CNT_W+1)'(1);
    assign exp_o = ({1'b0, cnt_q} == last);
    assign cnt_o = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (!exp_o) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!res) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule : phase_timer
`default_nettype wire

// File: rtl/cruzamento_ctrl.sv
`default_nettype none
// ============================================================================
// cruzamento_ctrl : Moore traffic-light controller for a main road A and a
//                   side road B; CRUZAMENTO_PED_EN adds a pedestrian WALK phase
// Revision        : 1.0
// ============================================================================
module cruzamento_ctrl
    import cruzamento_pkg::*;
#(
    parameter int GREEN_MIN = DEF_GREEN_MIN,
    parameter int GREEN_MAX = DEF_GREEN_MAX,
    parameter int YELLOW_T  = DEF_YELLOW_T,
    parameter int RED_T     = DEF_RED_T,
`ifdef CRUZAMENTO_PED_EN
    parameter int WALK_T    = DEF_WALK_T,
`endif
    parameter int CNT_W     = DEF_CNT_W
) (
    input  logic       clk,
    input  logic       res,
    input  logic       car_a,
    input  logic       car_b,
`ifdef CRUZAMENTO_PED_EN
    input  logic       ped_req,
    output logic       walk,
`endif
    output logic       grn_a,
    output logic       ylw_a,
    output logic       red_a,
    output logic       grn_b,
    output logic       ylw_b,
    output logic       red_b,
    output logic [2:0] phase
);

    localparam logic [CNT_W-1:0] GMIN_M1  = CNT_W'(GREEN_MIN - 1);
    localparam logic [CNT_W:0]   LIM_GMIN = (CNT_W+1)'(GREEN_MIN);
    localparam logic [CNT_W:0]   LIM_GMAX = (CNT_W+1)'(GREEN_MAX);
    localparam logic [CNT_W:0]   LIM_YLW  = (CNT_W+1)'(YELLOW_T);
    localparam logic [CNT_W:0]   LIM_RED  = (CNT_W+1)'(RED_T);

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W:0]   lim;
    logic [CNT_W-1:0] cnt;
    logic             expired;
    logic             min_done;
    logic             ped_pend;

    phase_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk   (clk),
        .res   (res),
        .clr_i (state_d != state_q),
        .lim_i (lim),
        .cnt_o (cnt),
        .exp_o (expired)
    );

    assign min_done = (cnt >= GMIN_M1);

`ifdef CRUZAMENTO_PED_EN
    localparam logic [CNT_W:0] LIM_WALK = (CNT_W+1)'(WALK_T);

    logic   ped_pend_q;
    state_t nxt_q;

    // Clearing on WALK entry wins over a request sampled on that same edge.
    always_ff @(posedge clk) begin
        if (!res) begin
            ped_pend_q <= 1'b0;
            nxt_q      <= B_GRN;
        end else begin
            if (state_d == WALK && state_q != WALK) begin
                ped_pend_q <= 1'b0;
            end else if (ped_req && state_q != WALK) begin
                ped_pend_q <= 1'b1;
            end
            if (state_q == RED_AB) begin
                nxt_q <= B_GRN;
            end else if (state_q == RED_BA) begin
                nxt_q <= A_GRN;
            end
        end
    end

    assign ped_pend = ped_pend_q;
    assign walk     = (state_q == WALK);
`else
    assign ped_pend = 1'b0;
`endif

    always_comb begin
        lim = LIM_RED;
        case (state_q)
            A_GRN:        lim = LIM_GMIN;
            B_GRN:        lim = LIM_GMAX;
            A_YLW, B_YLW: lim = LIM_YLW;
`ifdef CRUZAMENTO_PED_EN
            WALK:         lim = LIM_WALK;
`endif
            default:      lim = LIM_RED;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            A_GRN: begin
                if (min_done && (car_b || ped_pend)) state_d = A_YLW;
            end
            A_YLW: begin
                if (expired) state_d = RED_AB;
            end
            RED_AB: begin
                if (expired) begin
                    state_d = B_GRN;
`ifdef CRUZAMENTO_PED_EN
                    if (ped_pend) state_d = WALK;
`endif
                end
            end
            B_GRN: begin
                // With the timer limited to GREEN_MAX, expiry is the forced hand-back.
                if ((min_done && (!car_b || car_a || ped_pend)) || expired) state_d = B_YLW;
            end
            B_YLW: begin
                if (expired) state_d = RED_BA;
            end
            RED_BA: begin
                if (expired) begin
                    state_d = A_GRN;
`ifdef CRUZAMENTO_PED_EN
                    if (ped_pend) state_d = WALK;
`endif
                end
            end
`ifdef CRUZAMENTO_PED_EN
            WALK: begin
                if (expired) state_d = nxt_q;
            end
`endif
            default: state_d = A_GRN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!res) begin
            state_q <= A_GRN;
        end else begin
            state_q <= state_d;
        end
    end

    assign grn_a = (state_q == A_GRN);
    assign ylw_a = (state_q == A_YLW);
    assign red_a = !(grn_a || ylw_a);
    assign grn_b = (state_q == B_GRN);
    assign ylw_b = (state_q == B_YLW);
    assign red_b = !(grn_b || ylw_b);
    assign phase = state_q;

endmodule : cruzamento_ctrl
`default_nettype wire
